ip4_sm_mbk: RTL and testbench

- Parametrised multi-bank, multi-channel successor to the single-bank shared-memory building block.
- NBK word-interleaved banks are shared by NCH independent request channels.
- Each bank has a round-robin arbiter with valid/ready back-pressure on losing channels.
- Reads have a fixed 2-cycle response latency; writes support byte enables; a saturating bank-conflict counter is provided for performance statistics.

---
 rtl/ip4_sm_mbk.sv | 116 +++++++++++
 tb/tb_ip4_sm_mbk.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip4_sm_mbk.sv
// rtl/ip4_sm_mbk.sv - multi-bank multi-channel shared memory with per-bank round-robin arbitration
module ip4_sm_mbk #(
    parameter int NBK = 4,
    parameter int NCH = 2,
    parameter int AW  = 10,
    parameter int DW  = 32,
    parameter int CW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           req_vld,
    input  logic [NCH-1:0]           req_wr,
    input  logic [NCH-1:0][AW-1:0]   req_adr,
    input  logic [NCH-1:0][DW/8-1:0] req_be,
    input  logic [NCH-1:0][DW-1:0]   req_dat,
    output logic [NCH-1:0]           req_rdy,
    output logic [NCH-1:0]           rsp_vld,
    output logic [NCH-1:0][DW-1:0]   rsp_dat,
    output logic [CW-1:0]            stat_cnf,
    input  logic                     stat_clr
);
    localparam int BW = $clog2(NBK);
    localparam int RW = AW - BW;
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NB = DW / 8;

    logic [PW-1:0]           ptr    [NBK];
    logic [PW-1:0]           bk_win [NBK];
    logic [NBK-1:0]          bk_act;
    logic [NBK-1:0]          bk_en;
    logic [NCH-1:0]          gnt;
    logic [NCH-1:0]          s1_vld;
    logic [BW-1:0]           s1_bk  [NCH];
    logic [NBK-1:0][DW-1:0]  rdq_all;

    // Per-bank scan starting at the pointer; first matching valid channel wins.
    always_comb begin
        gnt    = '0;
        bk_act = '0;
        for (int b = 0; b < NBK; b++) begin
            bk_win[b] = '0;
        end
        for (int b = 0; b < NBK; b++) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = int'(ptr[b]) + k;
                if (c >= NCH) c = c - NCH;
                if (!bk_act[b] && req_vld[c] && (int'(req_adr[c][BW-1:0]) == b)) begin
                    bk_act[b] = 1'b1;
                    bk_win[b] = PW'(c);
                    gnt[c]    = 1'b1;
                end
            end
        end
    end

    assign req_rdy = rst_n ? gnt : '0;
    assign bk_en   = bk_act & {NBK{rst_n}};

    for (genvar b = 0; b < NBK; b++) begin : g_bank
        logic [DW-1:0] ram [2**RW];
        logic [DW-1:0] rdq;
        logic          wr;
        logic [RW-1:0] row;
        logic [NB-1:0] be;
        logic [DW-1:0] dat;

        assign wr  = req_wr[bk_win[b]];
        assign row = req_adr[bk_win[b]][AW-1:BW];
        assign be  = req_be[bk_win[b]];
        assign dat = req_dat[bk_win[b]];

        // Storage is deliberately left out of reset so it maps onto block RAM.
        always_ff @(posedge clk) begin
            if (bk_en[b]) begin
                if (wr) begin
                    for (int j = 0; j < NB; j++) begin
                        if (be[j]) ram[row][8*j +: 8] <= dat[8*j +: 8];
                    end
                end else begin
                    rdq <= ram[row];
                end
            end
        end

        assign rdq_all[b] = rdq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= '0;
            rsp_vld  <= '0;
            rsp_dat  <= '0;
            stat_cnf <= '0;
            for (int c = 0; c < NCH; c++) s1_bk[c] <= '0;
            for (int b = 0; b < NBK; b++) ptr[b] <= '0;
        end else begin
            s1_vld  <= req_rdy & ~req_wr;
            rsp_vld <= s1_vld;
            for (int c = 0; c < NCH; c++) begin
                s1_bk[c] <= req_adr[c][BW-1:0];
                if (s1_vld[c]) rsp_dat[c] <= rdq_all[s1_bk[c]];
            end
            for (int b = 0; b < NBK; b++) begin
                if (bk_act[b]) begin
                    ptr[b] <= (bk_win[b] == PW'(NCH - 1)) ? '0 : bk_win[b] + 1'b1;
                end
            end
            if (stat_clr) begin
                stat_cnf <= '0;
            end else if ((|(req_vld & ~req_rdy)) && (stat_cnf != {CW{1'b1}})) begin
                stat_cnf <= stat_cnf + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ip4_sm_mbk.sv
// tb/tb_ip4_sm_mbk.sv - scoreboard bench for ip4_sm_mbk
module tb_ip4_sm_mbk;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_vld;
    logic [1:0]        req_wr;
    logic [1:0][9:0]   req_adr;
    logic [1:0][3:0]   req_be;
    logic [1:0][31:0]  req_dat;
    logic [1:0]        req_rdy;
    logic [1:0]        rsp_vld;
    logic [1:0][31:0]  rsp_dat;
    logic [3:0]        stat_cnf;
    logic              stat_clr;

    typedef struct {
        logic [31:0] d;
        int          c;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [31:0] exp_dat [2];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          rcnt [2] = '{0, 0};

    ip4_sm_mbk #(.NBK(4), .NCH(2), .AW(10), .DW(32), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_wr(req_wr),
        .req_adr(req_adr), .req_be(req_be), .req_dat(req_dat), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_dat(rsp_dat), .stat_cnf(stat_cnf), .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: record accepted reads, then pop and compare whenever a response appears.
    always @(negedge clk) begin
        ent_t e;
        if (rst_n && req_vld[0] && req_rdy[0] && !req_wr[0]) q0.push_back('{exp_dat[0], cyc + 2});
        if (rst_n && req_vld[1] && req_rdy[1] && !req_wr[1]) q1.push_back('{exp_dat[1], cyc + 2});
        if (rsp_vld[0]) begin
            rcnt[0]++;
            if (q0.size() == 0) chk("ch0_unexpected_rsp", 1, 0);
            else begin
                e = q0.pop_front();
                chk("ch0_rsp_dat", rsp_dat[0], e.d);
                chk("ch0_rsp_cycle", cyc, e.c);
            end
        end
        if (rsp_vld[1]) begin
            rcnt[1]++;
            if (q1.size() == 0) chk("ch1_unexpected_rsp", 1, 0);
            else begin
                e = q1.pop_front();
                chk("ch1_rsp_dat", rsp_dat[1], e.d);
                chk("ch1_rsp_cycle", cyc, e.c);
            end
        end
    end

    task automatic rq(input int ch, input bit wr, input logic [9:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic [31:0] e);
        req_vld[ch] = 1'b1;
        req_wr[ch]  = wr;
        req_adr[ch] = a;
        req_be[ch]  = be;
        req_dat[ch] = d;
        exp_dat[ch] = e;
    endtask

    task automatic nxt(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input string nm, input logic [1:0] rdy);
        @(negedge clk);
        chk(nm, req_rdy, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int r0;
        int r1;
        rst_n    = 1'b0;
        stat_clr = 1'b0;
        req_vld  = 2'b00;
        req_wr   = '0;
        req_adr  = '0;
        req_be   = '0;
        req_dat  = '0;
        exp_dat  = '{32'h0, 32'h0};

        // Reset state, with requests pending
        rq(0, 1'b0, 10'h000, 4'hF, 32'h0, 32'h0);
        rq(1, 1'b0, 10'h001, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("reset_rdy", req_rdy, 2'b00);
        chk("reset_rsp_vld", rsp_vld, 2'b00);
        chk("reset_rsp_dat", rsp_dat, 64'h0);
        chk("reset_stat", stat_cnf, 4'd0);
        req_vld = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nxt(1);

        // Write then read through another channel
        rq(0, 1'b1, 10'h005, 4'hF, 32'hA5A5_1234, 32'h0);
        step("t1_wr_rdy", 2'b01);
        req_vld[0] = 1'b0;
        rq(1, 1'b0, 10'h005, 4'hF, 32'h0, 32'hA5A5_1234);
        step("t1_rd_rdy", 2'b10);
        req_vld[1] = 1'b0;
        nxt(4);
        chk("t1_stat", stat_cnf, 4'd0);

        // Bank 1 conflicts, round-robin ordering
        rq(0, 1'b1, 10'h001, 4'hF, 32'h0000_1111, 32'h0);
        step("t2_w0", 2'b01);
        rq(0, 1'b1, 10'h011, 4'hF, 32'h0000_2222, 32'h0);
        step("t2_w1", 2'b01);
        req_vld[0] = 1'b0;
        rq(1, 1'b1, 10'h021, 4'hF, 32'h0000_3333, 32'h0);
        step("t2_w2", 2'b10);
        req_vld[1] = 1'b0;
        rq(0, 1'b0, 10'h001, 4'h0, 32'h0, 32'h0000_1111);
        rq(1, 1'b0, 10'h011, 4'h0, 32'h0, 32'h0000_2222);
        step("t2_c0_ch0_wins", 2'b01);
        rq(0, 1'b0, 10'h021, 4'h0, 32'h0, 32'h0000_3333);
        step("t2_c1_ch1_wins", 2'b10);
        req_vld[1] = 1'b0;
        step("t2_c2_ch0", 2'b01);
        req_vld[0] = 1'b0;
        nxt(4);
        chk("t2_stat", stat_cnf, 4'd2);
        stat_clr = 1'b1;
        nxt(1);
        stat_clr = 1'b0;
        chk("t2_stat_clr", stat_cnf, 4'd0);

        // Byte-enable merge
        rq(0, 1'b1, 10'h008, 4'hF, 32'hFFFF_FFFF, 32'h0);
        step("t3_w_full", 2'b01);
        rq(0, 1'b1, 10'h008, 4'b0101, 32'h0000_0000, 32'h0);
        step("t3_w_be", 2'b01);
        rq(0, 1'b0, 10'h008, 4'h0, 32'h0, 32'hFF00_FF00);
        step("t3_rd", 2'b01);
        req_vld[0] = 1'b0;
        rq(1, 1'b1, 10'h00A, 4'hF, 32'hCAFE_0002, 32'h0);
        step("t3_w_bank2", 2'b10);
        req_vld[1] = 1'b0;
        nxt(3);

        // Streaming reads on different banks
        bad = 0;
        r0  = rcnt[0];
        r1  = rcnt[1];
        rq(0, 1'b0, 10'h008, 4'h0, 32'h0, 32'hFF00_FF00);
        rq(1, 1'b0, 10'h00A, 4'h0, 32'h0, 32'hCAFE_0002);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_rdy !== 2'b11) bad++;
            @(posedge clk);
            #1;
        end
        req_vld = 2'b00;
        nxt(4);
        chk("t4_stall_cycles", bad, 0);
        chk("t4_ch0_rsp_count", rcnt[0] - r0, 20);
        chk("t4_ch1_rsp_count", rcnt[1] - r1, 20);
        chk("t4_stat", stat_cnf, 4'd0);

        // Pointer on bank 1 is now 1: ch1 wins first
        rq(0, 1'b0, 10'h001, 4'h0, 32'h0, 32'h0000_1111);
        rq(1, 1'b0, 10'h011, 4'h0, 32'h0, 32'h0000_2222);
        step("t5_pre_ch1_wins", 2'b10);
        req_vld[1] = 1'b0;
        step("t5_pre_ch0", 2'b01);
        req_vld[0] = 1'b0;
        nxt(3);
        chk("t5_pre_stat", stat_cnf, 4'd1);

        // Reset with reads in flight
        rq(0, 1'b0, 10'h008, 4'h0, 32'h0, 32'hFF00_FF00);
        rq(1, 1'b0, 10'h00A, 4'h0, 32'h0, 32'hCAFE_0002);
        step("t5_acc", 2'b11);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("t5_rst_rdy", req_rdy, 2'b00);
        chk("t5_rst_rsp0", rsp_vld, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_rst_rsp1", rsp_vld, 2'b00);
        @(posedge clk);
        #1;
        req_vld = 2'b00;
        rst_n   = 1'b1;
        nxt(3);
        chk("t5_post_rsp", rsp_vld, 2'b00);
        chk("t5_post_stat", stat_cnf, 4'd0);
        rq(0, 1'b0, 10'h001, 4'h0, 32'h0, 32'h0000_1111);
        rq(1, 1'b0, 10'h011, 4'h0, 32'h0, 32'h0000_2222);
        step("t5_ptr_reset_ch0_wins", 2'b01);
        req_vld[0] = 1'b0;
        step("t5_post_ch1", 2'b10);
        req_vld[1] = 1'b0;
        nxt(3);

        // Counter saturation and clear priority
        stat_clr = 1'b1;
        nxt(1);
        stat_clr = 1'b0;
        chk("t6_clr_idle", stat_cnf, 4'd0);
        rq(0, 1'b1, 10'h003, 4'h0, 32'h0, 32'h0);
        rq(1, 1'b1, 10'h007, 4'h0, 32'h0, 32'h0);
        nxt(20);
        chk("t6_saturate", stat_cnf, 4'd15);
        nxt(3);
        chk("t6_hold", stat_cnf, 4'd15);
        stat_clr = 1'b1;
        @(negedge clk);
        chk("t6_clr_in_conflict_rdy", req_rdy == 2'b11, 1'b0);
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        chk("t6_clr_priority", stat_cnf, 4'd0);
        req_vld = 2'b00;

        nxt(4);
        chk("end_q0_empty", q0.size(), 0);
        chk("end_q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
